// File: rtl/instr_pkg.sv
// Shared types and sizing for the instruction RAM loader.
// Word geometry is derived from WIDTH/AMOUNT so the loader tracks the ROM.
package instr_pkg;

  localparam int WIDTH  = 24;
  localparam int AMOUNT = 256;
  localparam int BPW    = WIDTH / 8;
  localparam int AW     = $clog2(AMOUNT);
  localparam int BCW    = $clog2(BPW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_FULL,
    S_DONE
  } loader_state_t;

  // Move the n most recent bytes to the top of the word, zero below.
  function automatic logic [WIDTH-1:0] left_align(
    input logic [WIDTH-1:0] w,
    input int unsigned      n
  );
    return w << (8 * (BPW - n));
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream link from the host bridge into the loader.
// Transfer happens when byte_valid and byte_ready are both high.
interface instr_mem_loader_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    input  byte_last,
    output byte_ready
  );

endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// Packs MSB-first bytes into instruction words.
// An early last byte closes the word left-aligned with zero padding.
module byte_assembler
  import instr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic [7:0]       din,
  input  logic             last,
  output logic [WIDTH-1:0] word,
  output logic             word_full,
  output logic             pad
);

  logic [BCW-1:0]   cnt;
  logic [WIDTH-1:0] shifted;
  int unsigned      nbytes;

  always_comb begin
    shifted   = {word[WIDTH-9:0], din};
    nbytes    = 32'(cnt) + 1;
    word_full = shift && ((nbytes == BPW) || last);
    pad       = shift && last && (nbytes != BPW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (shift) begin
      if (word_full) begin
        cnt  <= '0;
        word <= pad ? left_align(shifted, nbytes) : shifted;
      end else begin
        cnt  <= cnt + 1'b1;
        word <= shifted;
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program image into instruction RAM and holds the
// processor in reset until the whole image has been written.
module instr_mem_loader
  import instr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  instr_mem_loader_if.slave  bus,
  output logic               we,
  output logic [WIDTH-1:0]   waddr,
  output logic [WIDTH-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic [AW:0]        word_count,
  output logic               frame_err,
  output logic               overflow_err,
  output logic               cpu_hold
);

  localparam logic [AW:0] LASTC = (AW + 1)'(AMOUNT - 1);

  loader_state_t state, nxt;

  logic [AW-1:0] addr;
  logic          last_q;
  logic          hs;
  logic          shift;
  logic          word_full;
  logic          pad;

  assign bus.byte_ready = (state == S_RECV) || (state == S_FULL);
  assign busy     = (state == S_RECV) || (state == S_WRITE)
                 || (state == S_FULL);
  assign done     = (state == S_DONE);
  assign cpu_hold = (state != S_DONE);
  assign waddr    = {{(WIDTH - AW){1'b0}}, addr};

  assign hs    = bus.byte_valid && bus.byte_ready;
  assign shift = hs && (state == S_RECV) && !start;

  byte_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start),
    .shift     (shift),
    .din       (bus.byte_data),
    .last      (bus.byte_last),
    .word      (wdata),
    .word_full (word_full),
    .pad       (pad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // start wins over everything, including a write in flight
  always_comb begin
    nxt = state;
    we  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = S_RECV;
      end
      S_RECV: begin
        if (start)          nxt = S_RECV;
        else if (word_full) nxt = S_WRITE;
      end
      S_WRITE: begin
        we = !start;
        if (start)                    nxt = S_RECV;
        else if (last_q)              nxt = S_DONE;
        else if (word_count == LASTC) nxt = S_FULL;
        else                          nxt = S_RECV;
      end
      S_FULL: begin
        if (start)                       nxt = S_RECV;
        else if (hs && bus.byte_last)    nxt = S_DONE;
      end
      S_DONE: begin
        if (start) nxt = S_RECV;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= '0;
      word_count   <= '0;
      last_q       <= 1'b0;
      frame_err    <= 1'b0;
      overflow_err <= 1'b0;
    end else if (start) begin
      addr         <= '0;
      word_count   <= '0;
      last_q       <= 1'b0;
      frame_err    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (shift && word_full) last_q <= bus.byte_last;
      if (pad) frame_err <= 1'b1;
      if ((state == S_FULL) && hs) overflow_err <= 1'b1;
      if (state == S_WRITE) begin
        word_count <= word_count + 1'b1;
        // the final slot keeps its address so waddr never wraps
        if (word_count != LASTC) addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: fixed vectors,
// random images against a word-packing model, abort and reset cases.
module tb_instr_mem_loader;
  import instr_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if bus();

  logic             we, busy, done, frame_err, overflow_err, cpu_hold;
  logic [WIDTH-1:0] waddr, wdata;
  logic [AW:0]      word_count;

  instr_mem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count),
    .frame_err    (frame_err),
    .overflow_err (overflow_err),
    .cpu_hold     (cpu_hold)
  );

  typedef struct packed {
    logic [23:0] a;
    logic [23:0] d;
  } wr_t;

  typedef struct {
    int          n;
    logic [7:0]  b [6];
    int          nw;
    logic [23:0] w [2];
    logic        fe;
  } vec_t;

  wr_t        wq[$];
  logic [7:0] img[$];
  int         viol = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  always @(negedge clk) begin
    if (rst_n && we) wq.push_back({waddr, wdata});
    if (we && bus.byte_ready) viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l,
                           input int gap);
    int t = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    bus.byte_last  = l;
    @(negedge clk);
    while (!bus.byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0, expected 1");
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_img(input bit gaps, input bit mark_last);
    for (int k = 0; k < img.size(); k++)
      send_byte(img[k], mark_last && (k == img.size() - 1),
                gaps ? int'($urandom_range(0, 1)) : 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done_wait", done, 1);
  endtask

  // expected word j: three image bytes MSB-first, missing bytes zero
  function automatic logic [23:0] exp_word(int j);
    logic [23:0] w = '0;
    for (int k = 0; k < 3; k++) begin
      int idx = 3 * j + k;
      w = {w[15:0], (idx < img.size()) ? img[idx] : 8'h00};
    end
    return w;
  endfunction

  task automatic check_model(input string tag);
    int n  = img.size();
    int nw = (n + 2) / 3;
    if (nw > AMOUNT) nw = AMOUNT;
    chk({tag, "_nwr"}, wq.size(), nw);
    for (int j = 0; j < nw && j < wq.size(); j++) begin
      chk($sformatf("%s_addr%0d", tag, j), wq[j].a, j);
      chk($sformatf("%s_data%0d", tag, j), wq[j].d, exp_word(j));
    end
    chk({tag, "_fe"}, frame_err, (n % 3 != 0) && (n <= 3 * AMOUNT));
    chk({tag, "_ovf"}, overflow_err, n > 3 * AMOUNT);
    chk({tag, "_cnt"}, word_count, nw);
    chk({tag, "_hold"}, cpu_hold, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    vec_t vt [5];
    vt[0] = '{6, '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF},
              2, '{24'h123456, 24'hABCDEF}, 1'b0};
    vt[1] = '{4, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00},
              2, '{24'h010203, 24'h040000}, 1'b1};
    vt[2] = '{1, '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              1, '{24'hAA0000, 24'h000000}, 1'b1};
    vt[3] = '{5, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00},
              2, '{24'h112233, 24'h445500}, 1'b1};
    vt[4] = '{3, '{8'hDE, 8'hAD, 8'hBE, 8'h00, 8'h00, 8'h00},
              1, '{24'hDEADBE, 24'h000000}, 1'b0};

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", bus.byte_ready, 0);
    chk("idle_hold", cpu_hold, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_wdata", wdata, 0);

    // fixed vectors
    for (int v = 0; v < 5; v++) begin
      img.delete();
      for (int k = 0; k < vt[v].n; k++) img.push_back(vt[v].b[k]);
      pulse_start();
      wq.delete();
      send_img(1'b0, 1'b1);
      wait_done();
      chk($sformatf("vec%0d_nwr", v), wq.size(), vt[v].nw);
      for (int j = 0; j < vt[v].nw && j < wq.size(); j++) begin
        chk($sformatf("vec%0d_addr%0d", v, j), wq[j].a, j);
        chk($sformatf("vec%0d_data%0d", v, j), wq[j].d, vt[v].w[j]);
      end
      chk($sformatf("vec%0d_fe", v), frame_err, vt[v].fe);
      chk($sformatf("vec%0d_cnt", v), word_count, vt[v].nw);
      chk($sformatf("vec%0d_ovf", v), overflow_err, 0);
      chk($sformatf("vec%0d_hold", v), cpu_hold, 0);
    end

    // random images with ~50% valid gaps
    for (int it = 0; it < 6; it++) begin
      int n = (it == 0) ? 30 : int'($urandom_range(1, 40));
      img.delete();
      for (int k = 0; k < n; k++) img.push_back(8'($urandom));
      pulse_start();
      wq.delete();
      send_img(1'b1, 1'b1);
      wait_done();
      check_model($sformatf("rnd%0d", it));
    end

    // exactly AMOUNT words, last on the final byte: no overflow
    img.delete();
    for (int k = 0; k < 3 * AMOUNT; k++) img.push_back(8'($urandom));
    pulse_start();
    wq.delete();
    send_img(1'b0, 1'b1);
    wait_done();
    check_model("exact");

    // AMOUNT words then extra bytes, last on the third extra
    for (int k = 0; k < 3; k++) img.push_back(8'($urandom));
    pulse_start();
    wq.delete();
    send_img(1'b0, 1'b1);
    wait_done();
    check_model("ovf");

    // abort while in FULL with overflow already flagged
    img.delete();
    for (int k = 0; k < 3 * AMOUNT + 1; k++) img.push_back(8'h5A);
    pulse_start();
    send_img(1'b0, 1'b0);
    chk("full_ovf_set", overflow_err, 1);
    pulse_start();
    chk("full_abort_ovf", overflow_err, 0);
    chk("full_abort_cnt", word_count, 0);
    chk("full_abort_ready", bus.byte_ready, 1);

    // start after 4 bytes, then a fresh 1-word image
    img.delete();
    for (int k = 0; k < 4; k++) img.push_back(8'(k + 1));
    pulse_start();
    send_img(1'b0, 1'b0);
    pulse_start();
    chk("abort4_cnt", word_count, 0);
    chk("abort4_fe", frame_err, 0);
    chk("abort4_done", done, 0);
    chk("abort4_busy", busy, 1);
    wq.delete();
    img.delete();
    img.push_back(8'hC0);
    img.push_back(8'hFF);
    img.push_back(8'hEE);
    send_img(1'b0, 1'b1);
    wait_done();
    check_model("fresh");

    // start landing on a WRITE cycle suppresses the write
    pulse_start();
    wq.delete();
    for (int k = 0; k < 3; k++) send_byte(8'h77, 1'b0, 0);
    start = 1'b1;
    @(negedge clk);
    chk("abort_we", we, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("abort_wr_cnt", word_count, 0);
    chk("abort_wr_nwr", wq.size(), 0);

    // reset in the middle of a load
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(8'h9C, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_cnt", word_count, 0);
    chk("rst_hold", cpu_hold, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", bus.byte_ready, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_hold", cpu_hold, 1);

    chk("we_while_ready", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
